// File: rtl/ccu_snoop_initiator.sv
// ACE snoop initiator: issues one AC snoop, collects CR and two CD beats, and returns one
// result per command. It also flags protocol faults and slow responders.

package snoop_pkg;
  typedef logic [3:0] acsnoop_t;

  localparam acsnoop_t READ_ONCE     = 4'b0000;
  localparam acsnoop_t READ_SHARED   = 4'b0001;
  localparam acsnoop_t READ_UNIQUE   = 4'b0111;
  localparam acsnoop_t CLEAN_INVALID = 4'b1001;

  typedef struct packed {
    logic wasUnique;
    logic isShared;
    logic passDirty;
    logic error;
    logic dataTransfer;
  } crresp_t;
endpackage

package ariane_ace;
  typedef struct packed {
    logic [63:0]         addr;
    snoop_pkg::acsnoop_t snoop;
    logic [2:0]          prot;
  } ac_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } cd_chan_t;

  typedef struct packed {
    logic     ac_valid;
    ac_chan_t ac;
    logic     cr_ready;
    logic     cd_ready;
  } snoop_req_t;

  typedef struct packed {
    logic               ac_ready;
    logic               cr_valid;
    snoop_pkg::crresp_t cr_resp;
    logic               cd_valid;
    cd_chan_t           cd;
  } snoop_resp_t;
endpackage

module ccu_snoop_initiator #(
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [63:0]            req_addr_i,
  input  snoop_pkg::acsnoop_t    req_snoop_i,
  output ariane_ace::snoop_req_t snoop_port_o,
  input  ariane_ace::snoop_resp_t snoop_port_i,
  output logic                   resp_valid_o,
  input  logic                   resp_ready_i,
  output snoop_pkg::crresp_t     resp_cr_o,
  output logic [127:0]           resp_data_o,
  output logic                   resp_error_o,
  output logic                   timeout_o,
  output logic                   busy_o
);
  import snoop_pkg::*;

  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StSendAc   = 3'd1;
  localparam logic [2:0] StWaitCr   = 3'd2;
  localparam logic [2:0] StRecvCd   = 3'd3;
  localparam logic [2:0] StSendResp = 3'd4;

  logic [2:0]      r_state,   w_state_nxt;
  logic [63:0]     r_addr,    w_addr_nxt;
  acsnoop_t        r_snoop,   w_snoop_nxt;
  crresp_t         r_cr,      w_cr_nxt;
  logic [127:0]    r_data,    w_data_nxt;
  logic            r_error,   w_error_nxt;
  logic            r_beat,    w_beat_nxt;
  logic [CntW-1:0] r_cnt,     w_cnt_nxt;
  logic            r_timeout, w_timeout_nxt;

  logic w_legal;
  logic w_in_wait;

  assign w_legal   = req_snoop_i inside {CLEAN_INVALID, READ_SHARED, READ_ONCE, READ_UNIQUE};
  assign w_in_wait = (r_state == StWaitCr) || (r_state == StRecvCd);

  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_addr;
    w_snoop_nxt   = r_snoop;
    w_cr_nxt      = r_cr;
    w_data_nxt    = r_data;
    w_error_nxt   = r_error;
    w_beat_nxt    = r_beat;
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = r_timeout;

    // Saturating wait counter; the snoop is never aborted, only flagged.
    if (w_in_wait) begin
      if (r_cnt != CntMax) w_cnt_nxt = r_cnt + 1'b1;
      if (w_cnt_nxt == CntMax) w_timeout_nxt = 1'b1;
    end

    unique case (r_state)
      StIdle: begin
        if (req_valid_i) begin
          w_addr_nxt    = req_addr_i & ~64'hF;
          w_snoop_nxt   = req_snoop_i;
          w_cr_nxt      = '0;
          w_data_nxt    = '0;
          w_beat_nxt    = 1'b0;
          w_cnt_nxt     = '0;
          w_timeout_nxt = 1'b0;
          w_error_nxt   = ~w_legal;
          w_state_nxt   = w_legal ? StSendAc : StSendResp;
        end
      end
      StSendAc: begin
        if (snoop_port_i.ac_ready) w_state_nxt = StWaitCr;
      end
      StWaitCr: begin
        if (snoop_port_i.cr_valid) begin
          w_cr_nxt = snoop_port_i.cr_resp;
          if (snoop_port_i.cr_resp.error) w_error_nxt = 1'b1;
          w_state_nxt = snoop_port_i.cr_resp.dataTransfer ? StRecvCd : StSendResp;
        end
      end
      StRecvCd: begin
        if (snoop_port_i.cd_valid) begin
          if (!r_beat) begin
            w_data_nxt[63:0] = snoop_port_i.cd.data;
            if (snoop_port_i.cd.last) w_error_nxt = 1'b1;
            w_beat_nxt = 1'b1;
          end else begin
            w_data_nxt[127:64] = snoop_port_i.cd.data;
            if (!snoop_port_i.cd.last) w_error_nxt = 1'b1;
            w_state_nxt = StSendResp;
          end
        end
      end
      StSendResp: begin
        if (resp_ready_i) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= StIdle;
      r_addr    <= '0;
      r_snoop   <= '0;
      r_cr      <= '0;
      r_data    <= '0;
      r_error   <= 1'b0;
      r_beat    <= 1'b0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_addr    <= w_addr_nxt;
      r_snoop   <= w_snoop_nxt;
      r_cr      <= w_cr_nxt;
      r_data    <= w_data_nxt;
      r_error   <= w_error_nxt;
      r_beat    <= w_beat_nxt;
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  always_comb begin
    snoop_port_o          = '0;
    snoop_port_o.ac_valid = (r_state == StSendAc);
    snoop_port_o.ac.addr  = r_addr;
    snoop_port_o.ac.snoop = r_snoop;
    snoop_port_o.ac.prot  = 3'b000;
    snoop_port_o.cr_ready = (r_state == StWaitCr);
    snoop_port_o.cd_ready = (r_state == StRecvCd);
  end

  assign req_ready_o  = (r_state == StIdle);
  assign busy_o       = (r_state != StIdle);
  assign resp_valid_o = (r_state == StSendResp);
  assign resp_cr_o    = r_cr;
  assign resp_data_o  = r_data;
  assign resp_error_o = r_error;
  assign timeout_o    = r_timeout;

endmodule

// File: tb/tb_ccu_snoop_initiator.sv
// Bench for ccu_snoop_initiator: a lockstep responder drives AC/CR/CD and a spec-level model
// predicts every result, handshake position and timeout flag.

module tb_ccu_snoop_initiator;
  import snoop_pkg::*;
  import ariane_ace::*;

  localparam int unsigned Tmo = 8;

  logic         clk;
  logic         rst_ni;
  logic         req_valid;
  logic         req_ready;
  logic [63:0]  req_addr;
  acsnoop_t     req_snoop;
  snoop_req_t   sp_o;
  snoop_resp_t  sp_i;
  logic         resp_valid;
  logic         resp_ready;
  crresp_t      resp_cr;
  logic [127:0] resp_data;
  logic         resp_error;
  logic         timeout;
  logic         busy;

  int checks = 0;
  int errors = 0;

  ccu_snoop_initiator #(.TimeoutCycles(Tmo)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_addr_i   (req_addr),
    .req_snoop_i  (req_snoop),
    .snoop_port_o (sp_o),
    .snoop_port_i (sp_i),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_cr_o    (resp_cr),
    .resp_data_o  (resp_data),
    .resp_error_o (resp_error),
    .timeout_o    (timeout),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // One whole snoop. Phases: 0 AC, 1 CR, 2 CD, 3 response; the DUT must track them exactly.
  task automatic do_snoop(input string name, input logic [63:0] addr, input acsnoop_t snp,
                          input crresp_t cr, input logic [63:0] d0, input logic [63:0] d1,
                          input logic l0, input logic l1, input int ac_wait, input int cr_wait,
                          input int cd_gap, input int rsp_wait, input int exp_lat,
                          input bit rst_mid);
    logic         legal;
    logic         exp_err;
    logic [127:0] exp_data;
    crresp_t      exp_cr;
    logic [63:0]  exp_addr;
    int ph, beat, waited, ac_hs, resp_cyc, acw, crw, cdg, rw;
    bit done;
    logic [3:0] got_ph, want_ph;

    legal    = snp inside {READ_ONCE, READ_SHARED, READ_UNIQUE, CLEAN_INVALID};
    exp_addr = {addr[63:4], 4'h0};
    exp_cr   = legal ? cr : crresp_t'(0);
    exp_data = (legal && cr.dataTransfer) ? {d1, d0} : 128'h0;
    exp_err  = !legal || cr.error || (cr.dataTransfer && (l0 || !l1));

    @(negedge clk);
    resp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: req_ready=%b busy=%b required 1 0", name, req_ready, busy);
    end
    req_valid = 1'b1;
    req_addr  = addr;
    req_snoop = snp;
    @(posedge clk);

    ph = legal ? 0 : 3;
    beat = 0; waited = 0; ac_hs = 0; resp_cyc = -1; done = 1'b0;
    acw = ac_wait; crw = cr_wait; cdg = cd_gap; rw = rsp_wait;
    for (int n = 1; n < 300 && !done; n++) begin
      @(negedge clk);
      req_valid  = 1'b0;
      req_addr   = {$urandom, $urandom};
      req_snoop  = acsnoop_t'($urandom);
      sp_i       = '0;
      sp_i.cd.data = {$urandom, $urandom};
      resp_ready = 1'b0;

      checks++;
      if (busy !== 1'b1 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s busy n=%0d: busy=%b req_ready=%b required 1 0", name, n, busy,
                 req_ready);
      end
      checks++;
      if (timeout !== (waited >= Tmo)) begin
        errors++;
        $display("FAIL %s timeout n=%0d: got %b required %b", name, n, timeout, waited >= Tmo);
      end
      got_ph  = {sp_o.ac_valid, sp_o.cr_ready, sp_o.cd_ready, resp_valid};
      want_ph = {ph == 0, ph == 1, ph == 2, ph == 3};
      checks++;
      if (got_ph !== want_ph) begin
        errors++;
        $display("FAIL %s phase n=%0d: ac_v/cr_r/cd_r/resp_v=%b required %b", name, n, got_ph,
                 want_ph);
      end
      if (sp_o.ac_valid) begin
        checks++;
        if (sp_o.ac.addr !== exp_addr || sp_o.ac.snoop !== snp || sp_o.ac.prot !== 3'b0) begin
          errors++;
          $display("FAIL %s ac fields: addr=%h snoop=%h prot=%h required %h %h 0", name,
                   sp_o.ac.addr, sp_o.ac.snoop, sp_o.ac.prot, exp_addr, snp);
        end
      end
      if (sp_o.cr_ready || sp_o.cd_ready) waited++;

      if (ph == 2 && beat == 1 && rst_mid) begin
        rst_ni = 1'b0;
        #1;
        return;
      end

      case (ph)
        0: begin
          if (acw > 0) acw--;
          else if (sp_o.ac_valid) begin
            sp_i.ac_ready = 1'b1;
            ph = 1;
          end
        end
        1: begin
          if (crw > 0) crw--;
          else begin
            sp_i.cr_valid = 1'b1;
            sp_i.cr_resp  = cr;
            // A stray CD beat alongside CR must be ignored.
            sp_i.cd_valid = 1'($urandom_range(0, 1));
            sp_i.cd.last  = 1'($urandom_range(0, 1));
            ph = cr.dataTransfer ? 2 : 3;
          end
        end
        2: begin
          if (beat == 1 && cdg > 0) cdg--;
          else begin
            sp_i.cd_valid = 1'b1;
            sp_i.cd.data  = (beat == 0) ? d0 : d1;
            sp_i.cd.last  = (beat == 0) ? l0 : l1;
            beat++;
            if (beat == 2) ph = 3;
          end
        end
        default: begin
          if (resp_cyc < 0) resp_cyc = n;
          checks++;
          if (resp_cr !== exp_cr || resp_data !== exp_data || resp_error !== exp_err) begin
            errors++;
            $display("FAIL %s resp: cr=%b data=%h err=%b required %b %h %b", name, resp_cr,
                     resp_data, resp_error, exp_cr, exp_data, exp_err);
          end
          if (rw > 0) rw--;
          else begin
            resp_ready = 1'b1;
            done = 1'b1;
          end
        end
      endcase
      if (sp_o.ac_valid && sp_i.ac_ready) ac_hs++;
    end

    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s bound: response not completed, phase=%0d required done", name, ph);
    end
    if (exp_lat >= 0) begin
      checks++;
      if (resp_cyc !== exp_lat) begin
        errors++;
        $display("FAIL %s latency: resp_valid at N+%0d required N+%0d", name, resp_cyc, exp_lat);
      end
    end
    checks++;
    if (ac_hs !== (legal ? 1 : 0)) begin
      errors++;
      $display("FAIL %s ac_handshakes: got %0d required %0d", name, ac_hs, legal ? 1 : 0);
    end
  endtask

  task automatic test_reset(input string tag);
    #1;
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0 || resp_error !== 1'b0 ||
        timeout !== 1'b0 || resp_cr !== crresp_t'(0) || resp_data !== 128'h0 || sp_o !== '0) begin
      errors++;
      $display("FAIL reset_%s: rdy=%b busy=%b rv=%b err=%b to=%b cr=%b data=%h port=%h", tag,
               req_ready, busy, resp_valid, resp_error, timeout, resp_cr, resp_data, sp_o);
    end
  endtask

  task automatic test_read_once_miss();
    do_snoop("read_once_miss", 64'h8000_1238, READ_ONCE, crresp_t'(5'b00000), 64'h0, 64'h0,
             1'b0, 1'b1, 0, 0, 0, 0, 3, 1'b0);
  endtask

  task automatic test_read_shared_hit();
    do_snoop("read_shared_hit", 64'h0000_0040_0000_1F7C, READ_SHARED, crresp_t'(5'b01001),
             64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b0, 1'b1, 0, 0, 0, 0, 5, 1'b0);
  endtask

  task automatic test_backpressure();
    do_snoop("backpressure", 64'h1234_5678_9ABC_DEF5, READ_UNIQUE, crresp_t'(5'b10101),
             64'hA5A5_0000_FFFF_0001, 64'h5A5A_1111_EEEE_0002, 1'b0, 1'b1, 3, 1, 2, 2, -1, 1'b0);
  endtask

  task automatic test_protocol_faults();
    do_snoop("beat0_last", 64'h0000_0000_0000_0100, READ_SHARED, crresp_t'(5'b00001),
             64'hDEAD_BEEF_0000_0000, 64'h0000_0000_CAFE_F00D, 1'b1, 1'b1, 0, 0, 0, 0, 5, 1'b0);
    do_snoop("illegal_type", 64'h0000_0000_0000_0200, acsnoop_t'(4'b1101), crresp_t'(5'b00001),
             64'h0, 64'h0, 1'b0, 1'b1, 0, 0, 0, 1, -1, 1'b0);
    do_snoop("cr_error", 64'h0000_0000_0000_0300, CLEAN_INVALID, crresp_t'(5'b00010),
             64'h0, 64'h0, 1'b0, 1'b1, 0, 0, 0, 0, 3, 1'b0);
  endtask

  task automatic test_timeout();
    do_snoop("timeout", 64'h0000_0000_0000_0410, READ_ONCE, crresp_t'(5'b00001),
             64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b1, 0, 20, 0, 0, -1, 1'b0);
    do_snoop("timeout_clear", 64'h0000_0000_0000_0420, READ_ONCE, crresp_t'(5'b00000),
             64'h0, 64'h0, 1'b0, 1'b1, 0, 0, 0, 0, 3, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_snoop("b2b_0", 64'h0000_0000_0000_1000, READ_SHARED, crresp_t'(5'b01001),
             64'h0000_0000_0000_00AA, 64'h0000_0000_0000_00BB, 1'b0, 1'b1, 0, 0, 0, 0, 5, 1'b0);
    do_snoop("b2b_1", 64'h0000_0000_0000_1010, acsnoop_t'(4'b0010), crresp_t'(5'b00000),
             64'h0, 64'h0, 1'b0, 1'b1, 0, 0, 0, 0, -1, 1'b0);
    do_snoop("b2b_2", 64'h0000_0000_0000_1020, CLEAN_INVALID, crresp_t'(5'b00000),
             64'h0, 64'h0, 1'b0, 1'b1, 0, 0, 0, 0, 3, 1'b0);
  endtask

  task automatic test_random();
    acsnoop_t snps [8];
    snps = '{READ_ONCE, READ_SHARED, READ_UNIQUE, CLEAN_INVALID,
             4'b0010, 4'b1000, 4'b1101, 4'b0011};
    for (int i = 0; i < 30; i++) begin
      do_snoop("random", {$urandom, $urandom}, snps[$urandom_range(0, 7)],
               crresp_t'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
               1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) != 0),
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), -1, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    do_snoop("reset_mid", 64'h0000_0000_0000_2008, READ_UNIQUE, crresp_t'(5'b00001),
             64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888, 1'b0, 1'b1, 0, 0, 0, 0, -1, 1'b1);
    sp_i = '0;
    resp_ready = 1'b0;
    test_reset("mid");
    @(negedge clk);
    rst_ni = 1'b1;
    do_snoop("after_reset", 64'h0000_0000_0000_3004, READ_SHARED, crresp_t'(5'b01001),
             64'h9999_0000_9999_0000, 64'h0000_AAAA_0000_AAAA, 1'b0, 1'b1, 0, 0, 0, 0, 5, 1'b0);
  endtask

  initial begin
    rst_ni     = 1'b0;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_snoop  = '0;
    sp_i       = '0;
    resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    test_reset("por");
    @(negedge clk);
    rst_ni = 1'b1;

    test_read_once_miss();
    test_read_shared_hit();
    test_backpressure();
    test_protocol_faults();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid();

    @(negedge clk);
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ccu_snoop_initiator.md
# ccu_snoop_initiator

Initiator end of the ACE snoop channel set (AC/CR/CD), placed in the coherence control unit on the interconnect side of one `std_cache` snoop port. It takes one snoop command at a time from the CCU, issues it on AC, collects the CR response and, when data is transferred, assembles the two 64-bit CD beats into one 128-bit cache line. It then returns a single result to the CCU. The block also flags responses that break the protocol and responders that are slow to answer.

## Interface
- `TimeoutCycles`, default 1024: number of cycles waited in WAIT_CR plus RECV_CD before `timeout_o` is raised; must be ≥ 1.
- `clk_i`  in  1  clock; single clock domain.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `req_valid_i`  in  1  CCU snoop command valid.
- `req_ready_o`  out  1  command accepted.
- `req_addr_i`  in  64  snoop address.
- `req_snoop_i`  in  `snoop_pkg::acsnoop_t`  snoop type.
- `snoop_port_o`  out  `ariane_ace::snoop_req_t`  carries `ac_valid`, `ac`, `cr_ready` and `cd_ready`.
- `snoop_port_i`  in  `ariane_ace::snoop_resp_t`  carries `ac_ready`, `cr_valid`, `cr_resp`, `cd_valid` and `cd`.
- `resp_valid_o`  out  1  result valid.
- `resp_ready_i`  in  1  CCU takes the result.
- `resp_cr_o`  out  `snoop_pkg::crresp_t`  captured CR response.
- `resp_data_o`  out  128  assembled line; 0 when no data was transferred.
- `resp_error_o`  out  1  illegal snoop type, CD `last` mismatch, or CR error bit.
- `timeout_o`  out  1  sticky; the responder exceeded `TimeoutCycles`.
- `busy_o`  out  1  state ≠ IDLE.

## Operation
- **States:** IDLE, SEND_AC, WAIT_CR, RECV_CD, SEND_RESP.
- **IDLE**
  - `req_ready_o=1`.
  - On `req_valid_i`, capture `{req_addr_i[63:4], 4'b0}` (line-aligned) and `req_snoop_i`.
  - Clear the result registers, the beat counter, the timeout counter and `timeout_o`.
  - Legal types are CLEAN_INVALID, READ_SHARED, READ_ONCE and READ_UNIQUE; a legal type goes to SEND_AC.
  - Any other type: go to SEND_RESP with `resp_error_o=1` and `resp_cr_o=0`; no AC is issued.
- **SEND_AC**
  - `ac_valid=1`; `ac.addr` is the aligned address, `ac.snoop` the captured type, `ac.prot=0`.
  - All AC fields stay stable until `ac_ready`.
  - Handshake (`ac_valid & ac_ready`) → WAIT_CR.
- **WAIT_CR**
  - `cr_ready=1`.
  - On `cr_valid`, capture `cr_resp`; if `cr_resp.error` is set, set the error bit.
  - `dataTransfer=1` → RECV_CD; otherwise → SEND_RESP.
- **RECV_CD**
  - `cd_ready=1`.
  - Beat 0 → `data[63:0]`; beat 1 → `data[127:64]`.
  - Expected `last` per beat: 0 on beat 0, 1 on beat 1. Any mismatch sets the error bit.
  - Collection always ends after exactly 2 beats; the accepted second beat → SEND_RESP.
- **SEND_RESP**
  - `resp_valid_o=1` and all `resp_*` outputs held stable until `resp_ready_i`, then → IDLE.
- **Timeout**
  - A saturating counter increments every cycle spent in WAIT_CR or RECV_CD.
  - When it reaches `TimeoutCycles`, `timeout_o` is set and stays set until the next command is accepted.
  - The FSM keeps waiting; it never aborts a snoop.
- **Reset mid-operation:** returns to IDLE immediately and drops all valids. The CCU must reissue the command.

## Timing
- **Reset values:** `req_ready_o=1`, `busy_o=0`, `resp_valid_o=0`, `resp_error_o=0`, `timeout_o=0`, `resp_cr_o=0`, `resp_data_o=0`, and every `snoop_port_o` field 0.
- `req_ready_o` is combinational from state only and does not depend on `req_valid_i`.
- All other outputs come from registers or from state only.
- **Cycle sequence:** command accepted in cycle N → `ac_valid` from N+1. With `ac_ready` in N+1, `cr_ready` is high from N+2.
- **Minimum latency:** with every responder handshake immediate, a no-data snoop has `resp_valid_o` at N+3, and a data snoop at N+5.
- **Back-to-back:** a new command is accepted in the cycle after the `resp_valid_o & resp_ready_i` handshake.
- **CD ordering:** `cd_ready` is never asserted before the CR handshake. The responder must send CR before CD.
- A CD beat and `cr_valid` in the same WAIT_CR cycle: only the CR is accepted.

## Test plan
- **READ_ONCE miss:** request addr 0x8000_1238 → `ac.addr`=0x8000_1230; CR `dataTransfer=0` → response `resp_cr_o=0`, `resp_data_o=0`, `resp_valid_o` at N+3.
- **READ_SHARED hit:**
  - Stimulus: CR `{dataTransfer=1, isShared=1}`; CD beats 0x1111_1111_1111_1111 (last=0), then 0x2222_2222_2222_2222 (last=1).
  - Required: `resp_data_o`=0x2222…2222_1111…1111, `resp_error_o=0`, `resp_valid_o` at N+5.
- **Backpressure:** `ac_ready` low for 3 cycles, `cd_ready` stall inserted between beats, `resp_ready_i` low for 2 cycles → `ac`/`resp_*` fields stay stable throughout, and exactly one AC handshake occurs.
- **Protocol faults:**
  - Beat 0 with last=1 → `resp_error_o=1`, and 2 beats are still consumed.
  - An illegal snoop type → `resp_error_o=1` with no `ac_valid` ever asserted.
- **Timeout:** `TimeoutCycles=8`, CR withheld for 20 cycles → `timeout_o` rises after 8 cycles, the response still completes normally, and `timeout_o` clears on the next command accept.
- **Reset mid-operation:** `rst_ni` asserted in RECV_CD after beat 0 → all outputs return to reset values asynchronously, and the next command proceeds normally.
